// File: rtl/llc_pkg.sv
// Shared types and derived widths for the last-level cache controller.
// The derived widths below describe the default geometry; the controller
// recomputes its own widths from its parameters.
package llc_pkg;

  localparam int unsigned LLC_ADDR_W     = 32;
  localparam int unsigned LLC_DATA_W     = 8;
  localparam int unsigned LLC_NUM_SETS   = 16;
  localparam int unsigned LLC_ASSOC      = 4;
  localparam int unsigned LLC_LINE_BYTES = 4;

  localparam int unsigned OFFSET_W = $clog2(LLC_LINE_BYTES);
  localparam int unsigned INDEX_W  = $clog2(LLC_NUM_SETS);
  localparam int unsigned TAG_W    = LLC_ADDR_W - OFFSET_W - INDEX_W;

  typedef struct packed {
    logic                                     valid;
    logic                                     dirty;
    logic [TAG_W-1:0]                         tag;
    logic [LLC_LINE_BYTES-1:0][LLC_DATA_W-1:0] data;
  } cache_line_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WB,
    ST_FILL_REQ,
    ST_FILL_WAIT
  } llc_state_e;

endpackage

// File: rtl/llc_plru_tree.sv
// Tree pseudo-LRU for one set: victim walk and access update (heap order,
// bit 0 selects the lower half, bit 1 the upper half). Purely combinational.
module llc_plru_tree #(
  parameter int unsigned ASSOC = 4
) (
  input  logic [ASSOC-2:0]         bits,
  input  logic [$clog2(ASSOC)-1:0] way,
  output logic [$clog2(ASSOC)-1:0] victim,
  output logic [ASSOC-2:0]         next_bits
);

  localparam int unsigned LEVELS = $clog2(ASSOC);

  logic [LEVELS-1:0] walk_node;
  logic              walk_bit;
  logic [LEVELS-1:0] upd_node;
  logic [LEVELS-1:0] upd_way;
  logic              upd_dir;

  // Follow the tree bits from the root; each bit chosen is one victim address bit.
  always_comb begin
    victim    = '0;
    walk_node = '0;
    walk_bit  = 1'b0;
    for (int unsigned l = 0; l < LEVELS; l++) begin
      walk_bit  = bits[walk_node];
      victim    = LEVELS'({victim, walk_bit});
      walk_node = LEVELS'({walk_node, 1'b0}) + LEVELS'(1) + LEVELS'(walk_bit);
    end
  end

  // Point every node on the accessed way's path away from that way.
  always_comb begin
    next_bits = bits;
    upd_node  = '0;
    upd_way   = way;
    upd_dir   = 1'b0;
    for (int unsigned l = 0; l < LEVELS; l++) begin
      upd_dir             = upd_way[LEVELS-1];
      next_bits[upd_node] = ~upd_dir;
      upd_node            = LEVELS'({upd_node, 1'b0}) + LEVELS'(1) + LEVELS'(upd_dir);
      upd_way             = upd_way << 1;
    end
  end

endmodule

// File: rtl/llc_cache_ctrl.sv
// Blocking write-back / write-allocate set-associative cache with tree PLRU.
// Optional statistics counters are built when LLC_STATS_EN is defined;
// otherwise the stat_* ports are tied to zero.
module llc_cache_ctrl
  import llc_pkg::*;
#(
  parameter int unsigned ADDR_W     = LLC_ADDR_W,
  parameter int unsigned DATA_W     = LLC_DATA_W,
  parameter int unsigned NUM_SETS   = LLC_NUM_SETS,
  parameter int unsigned ASSOC      = LLC_ASSOC,
  parameter int unsigned LINE_BYTES = LLC_LINE_BYTES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_wr,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  output logic                         resp_valid,
  output logic                         resp_hit,
  output logic [DATA_W-1:0]            resp_rdata,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic                         mem_req_wr,
  output logic [ADDR_W-1:0]            mem_req_addr,
  output logic [LINE_BYTES*DATA_W-1:0] mem_wdata,
  input  logic                         mem_resp_valid,
  input  logic [LINE_BYTES*DATA_W-1:0] mem_rdata,
  output logic [31:0]                  stat_hits,
  output logic [31:0]                  stat_misses,
  output logic [31:0]                  stat_wbacks
);

  localparam int unsigned OFF_BITS = $clog2(LINE_BYTES);
  localparam int unsigned IDX_BITS = $clog2(NUM_SETS);
  localparam int unsigned TAG_BITS = ADDR_W - OFF_BITS - IDX_BITS;
  localparam int unsigned WAY_BITS = $clog2(ASSOC);

  typedef logic [LINE_BYTES-1:0][DATA_W-1:0] line_t;

  llc_state_e state, state_nxt;

  logic                valid_q [NUM_SETS][ASSOC];
  logic                dirty_q [NUM_SETS][ASSOC];
  logic [TAG_BITS-1:0] tag_q   [NUM_SETS][ASSOC];
  line_t               data_q  [NUM_SETS][ASSOC];
  logic [ASSOC-2:0]    plru_q  [NUM_SETS];

  logic [ADDR_W-1:0]   lat_addr;
  logic                lat_wr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [WAY_BITS-1:0] vic;

  logic [OFF_BITS-1:0] lat_off;
  logic [IDX_BITS-1:0] lat_idx;
  logic [TAG_BITS-1:0] lat_tag;

  logic                hit;
  logic [WAY_BITS-1:0] hit_way;
  logic                inv_found;
  logic [WAY_BITS-1:0] inv_way;
  logic [WAY_BITS-1:0] miss_way;
  logic [WAY_BITS-1:0] plru_victim;
  logic [WAY_BITS-1:0] plru_way;
  logic [ASSOC-2:0]    plru_nxt;
  line_t               fill_line;

  assign lat_off = lat_addr[OFF_BITS-1:0];
  assign lat_idx = lat_addr[OFF_BITS +: IDX_BITS];
  assign lat_tag = lat_addr[ADDR_W-1 -: TAG_BITS];

  // Tag match and lowest-index invalid way for the latched request's set.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < ASSOC; w++) begin
      if (valid_q[lat_idx][w] && (tag_q[lat_idx][w] == lat_tag) && !hit) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
      if (!valid_q[lat_idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_BITS'(w);
      end
    end
  end

  assign miss_way = inv_found ? inv_way : plru_victim;
  assign plru_way = (state == ST_FILL_WAIT) ? vic : hit_way;

  llc_plru_tree #(.ASSOC(ASSOC)) u_plru (
    .bits      (plru_q[lat_idx]),
    .way       (plru_way),
    .victim    (plru_victim),
    .next_bits (plru_nxt)
  );

  // Incoming fill line with the pending write byte merged in.
  always_comb begin
    fill_line = mem_rdata;
    if (lat_wr) fill_line[lat_off] = lat_wdata;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake/memory-port outputs.
  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_wr    = 1'b0;
    mem_req_addr  = '0;
    mem_wdata     = '0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (hit)
          state_nxt = ST_IDLE;
        else if (valid_q[lat_idx][miss_way] && dirty_q[lat_idx][miss_way])
          state_nxt = ST_WB;
        else
          state_nxt = ST_FILL_REQ;
      end
      ST_WB: begin
        mem_req_valid = 1'b1;
        mem_req_wr    = 1'b1;
        mem_req_addr  = {tag_q[lat_idx][vic], lat_idx, {OFF_BITS{1'b0}}};
        mem_wdata     = data_q[lat_idx][vic];
        if (mem_req_ready) state_nxt = ST_FILL_REQ;
      end
      ST_FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {lat_tag, lat_idx, {OFF_BITS{1'b0}}};
        if (mem_req_ready) state_nxt = ST_FILL_WAIT;
      end
      ST_FILL_WAIT: begin
        if (mem_resp_valid) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, cache arrays, PLRU state and the response register.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '{default: '0};
      dirty_q    <= '{default: '0};
      plru_q     <= '{default: '0};
      lat_addr   <= '0;
      lat_wr     <= 1'b0;
      lat_wdata  <= '0;
      vic        <= '0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_addr  <= req_addr;
            lat_wr    <= req_wr;
            lat_wdata <= req_wdata;
          end
        end
        ST_LOOKUP: begin
          if (hit) begin
            if (lat_wr) begin
              data_q[lat_idx][hit_way][lat_off] <= lat_wdata;
              dirty_q[lat_idx][hit_way]         <= 1'b1;
              resp_rdata                        <= lat_wdata;
            end else begin
              resp_rdata <= data_q[lat_idx][hit_way][lat_off];
            end
            plru_q[lat_idx] <= plru_nxt;
            resp_valid      <= 1'b1;
            resp_hit        <= 1'b1;
          end else begin
            vic <= miss_way;
          end
        end
        ST_FILL_WAIT: begin
          if (mem_resp_valid) begin
            valid_q[lat_idx][vic] <= 1'b1;
            dirty_q[lat_idx][vic] <= lat_wr;
            tag_q[lat_idx][vic]   <= lat_tag;
            data_q[lat_idx][vic]  <= fill_line;
            plru_q[lat_idx]       <= plru_nxt;
            resp_valid            <= 1'b1;
            resp_hit              <= 1'b0;
            resp_rdata            <= fill_line[lat_off];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LLC_STATS_EN
  // Saturating event counters: hit responses, miss responses, accepted writebacks.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_wbacks <= '0;
    end else begin
      if (state == ST_LOOKUP && hit && stat_hits != '1)
        stat_hits <= stat_hits + 32'd1;
      if (state == ST_FILL_WAIT && mem_resp_valid && stat_misses != '1)
        stat_misses <= stat_misses + 32'd1;
      if (state == ST_WB && mem_req_ready && stat_wbacks != '1)
        stat_wbacks <= stat_wbacks + 32'd1;
    end
  end
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
  assign stat_wbacks = '0;
`endif

endmodule

// File: tb/tb_llc_cache_ctrl.sv
// Self-checking bench for llc_cache_ctrl (default geometry). A golden byte
// memory predicts every read; a tag/PLRU model of the cache predicts hits,
// victims and writebacks; a backing memory answers the DUT's line requests.
module tb_llc_cache_ctrl;

  localparam int unsigned NS  = 16;
  localparam int unsigned NW  = 4;
  localparam int unsigned LB  = 4;
  localparam int unsigned LVL = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wr;
  logic [31:0] req_addr;
  logic [7:0]  req_wdata;
  logic        resp_valid, resp_hit;
  logic [7:0]  resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_wr;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic [31:0] stat_hits, stat_misses, stat_wbacks;

  always #5 clk = ~clk;

  llc_cache_ctrl #(
    .ADDR_W(32), .DATA_W(8), .NUM_SETS(16), .ASSOC(4), .LINE_BYTES(4)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wr(mem_req_wr), .mem_req_addr(mem_req_addr), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_wbacks(stat_wbacks)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  gm   [int unsigned];
  logic [7:0]  bmem [int unsigned];
  bit          m_valid [NS][NW];
  bit          m_dirty [NS][NW];
  int unsigned m_tag   [NS][NW];
  int unsigned m_plru  [NS];
  int unsigned m_hits, m_misses, m_wbacks;

  logic        last_hit;
  logic [7:0]  last_rdata;
  int          last_lat;
  int          last_wb_cnt;
  int          last_stall;
  logic [31:0] last_wb_addr, last_wb_data, last_fill_addr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] init_byte(input int unsigned a);
    return 8'((a * 37 + 5) & 255);
  endfunction

  function automatic logic [7:0] gm_rd(input int unsigned a);
    return gm.exists(a) ? gm[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] bm_rd(input int unsigned a);
    return bmem.exists(a) ? bmem[a] : init_byte(a);
  endfunction

  function automatic logic [31:0] gm_line(input int unsigned a);
    return {gm_rd(a + 3), gm_rd(a + 2), gm_rd(a + 1), gm_rd(a)};
  endfunction

  function automatic logic [31:0] bm_line(input int unsigned a);
    return {bm_rd(a + 3), bm_rd(a + 2), bm_rd(a + 1), bm_rd(a)};
  endfunction

  function automatic int unsigned plru_pick(input int unsigned s);
    int unsigned node = 0;
    int unsigned way  = 0;
    for (int l = 0; l < LVL; l++) begin
      int unsigned b = (m_plru[s] >> node) & 1;
      way  = way * 2 + b;
      node = 2 * node + 1 + b;
    end
    return way;
  endfunction

  function automatic void plru_touch(input int unsigned s, input int unsigned w);
    int unsigned node = 0;
    for (int l = 0; l < LVL; l++) begin
      int unsigned dir = (w >> (LVL - 1 - l)) & 1;
      if (dir == 1) m_plru[s] = m_plru[s] & ~(32'd1 << node);
      else          m_plru[s] = m_plru[s] | (32'd1 << node);
      node = 2 * node + 1 + dir;
    end
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < NS; s++) begin
      m_plru[s] = 0;
      for (int w = 0; w < NW; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_tag[s][w]   = 0;
      end
    end
    m_hits = 0; m_misses = 0; m_wbacks = 0;
  endfunction

  // One core request, acting as memory slave until the response arrives.
  task automatic do_req(input bit wr, input int unsigned addr, input logic [7:0] wd,
                        input int stall);
    int unsigned off  = addr % LB;
    int unsigned s    = (addr / LB) % NS;
    int unsigned t    = addr / (LB * NS);
    int unsigned line = addr - off;
    bit          exp_hit = 1'b0;
    bit          exp_wb  = 1'b0;
    int unsigned way = 0;
    int unsigned wb_line = 0;
    logic [7:0]  exp_rd;
    int          guard = 0;
    int          cyc = 1;
    bit          got = 1'b0;
    int          fill_cnt = 0;
    int          resp_in = -1;
    int          stall_left = stall;
    bit          prev_pend = 1'b0;
    logic        prev_wr;
    logic [31:0] prev_addr, prev_wdata;
    bit          rdy;
    logic [31:0] d;

    for (int w = 0; w < NW; w++)
      if (!exp_hit && m_valid[s][w] && m_tag[s][w] == t) begin
        exp_hit = 1'b1;
        way = w;
      end
    if (!exp_hit) begin
      bit found = 1'b0;
      for (int w = 0; w < NW; w++)
        if (!found && !m_valid[s][w]) begin
          found = 1'b1;
          way = w;
        end
      if (!found) way = plru_pick(s);
      exp_wb  = m_valid[s][way] && m_dirty[s][way];
      wb_line = (m_tag[s][way] * NS + s) * LB;
    end
    exp_rd = wr ? wd : gm_rd(addr);

    last_wb_cnt = 0; last_stall = 0; last_wb_addr = '0; last_wb_data = '0;
    last_fill_addr = '0;

    while (!req_ready && guard < 20) begin
      tick();
      guard++;
    end
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL req_ready_wait: got %b want 1 (addr %h)", req_ready, addr);
    end
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd;
    tick();
    req_valid = 1'b0; req_wr = $urandom_range(0, 1); req_addr = $urandom;
    req_wdata = 8'($urandom);

    while (!got && cyc < 300) begin
      mem_resp_valid = 1'b0;
      mem_rdata      = $urandom;
      if (resp_in == 0) begin
        mem_resp_valid = 1'b1;
        mem_rdata      = bm_line(line);
        resp_in        = -1;
      end else if (resp_in > 0) begin
        resp_in--;
      end
      if (resp_valid === 1'b1) begin
        got = 1'b1;
      end else begin
        if (mem_req_valid === 1'b1) begin
          n_tests++;
          if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL req_ready_busy: got %b want 0", req_ready);
          end
          if (prev_pend) begin
            n_tests++;
            if (mem_req_wr !== prev_wr || mem_req_addr !== prev_addr ||
                mem_wdata !== prev_wdata) begin
              n_fail++;
              $display("FAIL mem_stable: got wr=%b addr=%h data=%h want wr=%b addr=%h data=%h",
                       mem_req_wr, mem_req_addr, mem_wdata, prev_wr, prev_addr, prev_wdata);
            end
          end
          n_tests++;
          if (mem_req_wr === 1'b1) begin
            if (!exp_wb || last_wb_cnt != 0 || mem_req_addr !== wb_line ||
                mem_wdata !== gm_line(wb_line)) begin
              n_fail++;
              $display("FAIL wb_req: got addr=%h data=%h want wb=%0d addr=%h data=%h",
                       mem_req_addr, mem_wdata, exp_wb, wb_line, gm_line(wb_line));
            end
          end else begin
            if (exp_hit || fill_cnt != 0 || mem_req_addr !== line ||
                (exp_wb && last_wb_cnt != 1)) begin
              n_fail++;
              $display("FAIL fill_req: got addr=%h wbs=%0d want addr=%h wb=%0d",
                       mem_req_addr, last_wb_cnt, line, exp_wb);
            end
          end
          mem_resp_valid = ($urandom_range(0, 1) == 1);
          rdy = ($urandom_range(0, 2) != 0);
          if (mem_req_wr === 1'b1 && stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
            last_stall++;
          end
          mem_req_ready = rdy;
          if (rdy) begin
            if (mem_req_wr === 1'b1) begin
              last_wb_cnt++;
              last_wb_addr = mem_req_addr;
              last_wb_data = mem_wdata;
              d = mem_wdata;
              bmem[mem_req_addr]     = d[7:0];
              bmem[mem_req_addr + 1] = d[15:8];
              bmem[mem_req_addr + 2] = d[23:16];
              bmem[mem_req_addr + 3] = d[31:24];
            end else begin
              fill_cnt++;
              last_fill_addr = mem_req_addr;
              resp_in = $urandom_range(0, 3);
            end
          end
          prev_pend  = !rdy;
          prev_wr    = mem_req_wr;
          prev_addr  = mem_req_addr;
          prev_wdata = mem_wdata;
        end else begin
          mem_req_ready = 1'b0;
          prev_pend = 1'b0;
        end
        tick();
        cyc++;
      end
    end
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;

    last_hit = resp_hit; last_rdata = resp_rdata; last_lat = cyc;
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL resp_timeout: got no response want response (addr %h)", addr);
    end else if (resp_hit !== exp_hit || resp_rdata !== exp_rd) begin
      n_fail++;
      $display("FAIL resp: addr=%h wr=%0d got hit=%b rdata=%h want hit=%0d rdata=%h",
               addr, wr, resp_hit, resp_rdata, exp_hit, exp_rd);
    end
    n_tests++;
    if ((exp_hit && cyc != 2) || last_wb_cnt != int'(exp_wb) || fill_cnt != int'(!exp_hit)) begin
      n_fail++;
      $display("FAIL txn_shape: got lat=%0d wbs=%0d fills=%0d want hit=%0d wb=%0d",
               cyc, last_wb_cnt, fill_cnt, exp_hit, exp_wb);
    end
    tick();
    n_tests++;
    if (resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL resp_pulse: got resp_valid=%b want 0", resp_valid);
    end

    if (exp_hit) begin
      if (wr) m_dirty[s][way] = 1'b1;
      m_hits++;
    end else begin
      if (exp_wb) m_wbacks++;
      m_valid[s][way] = 1'b1;
      m_dirty[s][way] = wr;
      m_tag[s][way]   = t;
      m_misses++;
    end
    plru_touch(s, way);
    if (wr) gm[addr] = wd;

    n_tests++;
`ifdef LLC_STATS_EN
    if (stat_hits !== m_hits || stat_misses !== m_misses || stat_wbacks !== m_wbacks) begin
      n_fail++;
      $display("FAIL stats: got %0d/%0d/%0d want %0d/%0d/%0d", stat_hits, stat_misses,
               stat_wbacks, m_hits, m_misses, m_wbacks);
    end
`else
    if (stat_hits !== 32'd0 || stat_misses !== 32'd0 || stat_wbacks !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_tied: got %0d/%0d/%0d want 0/0/0", stat_hits, stat_misses,
               stat_wbacks);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_req_valid !== 1'b0 ||
        mem_req_addr !== 32'd0 || mem_wdata !== 32'd0 || resp_rdata !== 8'd0 ||
        stat_hits !== 32'd0 || stat_misses !== 32'd0 || stat_wbacks !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b rv=%b mv=%b ma=%h wd=%h rd=%h want 1 0 0 0 0 0",
               req_ready, resp_valid, mem_req_valid, mem_req_addr, mem_wdata, resp_rdata);
    end
    reset = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_directed();
    logic [7:0] pre [4];
    pre[0] = 8'h11; pre[1] = 8'h22; pre[2] = 8'h33; pre[3] = 8'h44;
    for (int b = 0; b < 4; b++) begin
      bmem[32'h10 + b] = pre[b];
      gm[32'h10 + b]   = pre[b];
    end
    do_req(1'b0, 32'h10, 8'h00, 0);
    n_tests++;
    if (last_hit !== 1'b0 || last_rdata !== 8'h11 || last_fill_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL cold_read: got hit=%b rd=%h fill=%h want 0 11 00000010",
               last_hit, last_rdata, last_fill_addr);
    end
    do_req(1'b0, 32'h11, 8'h00, 0);
    n_tests++;
    if (last_hit !== 1'b1 || last_rdata !== 8'h22 || last_lat != 2) begin
      n_fail++;
      $display("FAIL hit_read: got hit=%b rd=%h lat=%0d want 1 22 2",
               last_hit, last_rdata, last_lat);
    end
    do_req(1'b1, 32'h10, 8'hAB, 0);
    do_req(1'b0, 32'h10, 8'h00, 0);
    n_tests++;
    if (last_hit !== 1'b1 || last_rdata !== 8'hAB) begin
      n_fail++;
      $display("FAIL write_then_read: got hit=%b rd=%h want 1 ab", last_hit, last_rdata);
    end
    do_req(1'b0, 32'h50, 8'h00, 0);
    do_req(1'b0, 32'h90, 8'h00, 0);
    do_req(1'b0, 32'hD0, 8'h00, 0);
    do_req(1'b0, 32'h110, 8'h00, 0);
    n_tests++;
    if (last_wb_cnt != 1 || last_wb_addr !== 32'h10 || last_wb_data !== 32'h443322AB ||
        last_fill_addr !== 32'h110 || last_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL evict_way0: got wbs=%0d wa=%h wd=%h fa=%h want 1 00000010 443322ab 00000110",
               last_wb_cnt, last_wb_addr, last_wb_data, last_fill_addr);
    end
  endtask

  task automatic test_wb_stall();
    for (int unsigned t = 0; t < 5; t++)
      do_req(1'b1, (t * NS + 5) * LB + $urandom_range(0, 3), 8'($urandom), 5);
    n_tests++;
    if (last_wb_cnt != 1 || last_stall != 5) begin
      n_fail++;
      $display("FAIL wb_stall: got wbs=%0d stalls=%0d want 1 5", last_wb_cnt, last_stall);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      int unsigned t = $urandom_range(0, 5);
      int unsigned s = $urandom_range(0, 3);
      int unsigned o = $urandom_range(0, 3);
      do_req($urandom_range(0, 1) == 1, (t * NS + s) * LB + o, 8'($urandom),
             $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_midmiss();
    int  guard = 0;
    bit  filled = 1'b0;
    logic [31:0] d;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = (9 * NS + 2) * LB; req_wdata = 8'h00;
    tick();
    req_valid = 1'b0;
    while (!filled && guard < 50) begin
      mem_req_ready = 1'b0;
      if (mem_req_valid === 1'b1) begin
        mem_req_ready = 1'b1;
        if (mem_req_wr === 1'b1) begin
          d = mem_wdata;
          bmem[mem_req_addr]     = d[7:0];
          bmem[mem_req_addr + 1] = d[15:8];
          bmem[mem_req_addr + 2] = d[23:16];
          bmem[mem_req_addr + 3] = d[31:24];
        end else begin
          filled = 1'b1;
        end
      end
      tick();
      guard++;
    end
    mem_req_ready = 1'b0;
    n_tests++;
    if (!filled) begin
      n_fail++;
      $display("FAIL midmiss_fill_req: got no fill request want one");
    end
    tick();
    reset = 1'b1;
    tick();
    n_tests++;
    if (mem_req_valid !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midmiss: got mv=%b rdy=%b rv=%b want 0 1 0",
               mem_req_valid, req_ready, resp_valid);
    end
    reset = 1'b0;
    gm = bmem;
    model_reset();
    do_req(1'b0, 32'h10, 8'h00, 0);
    n_tests++;
    if (last_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_miss: got hit=%b want 0", last_hit);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    model_reset();
    test_reset();
    test_directed();
    test_wb_stall();
    test_random();
    test_reset_midmiss();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
